// File: rtl/fir_decim2.sv
// fir_decim2: coefficient-programmable FIR filter with decimation by two.
// Samples go into a 2*TAPS ring. Every second input sample starts a serial
// multiply-accumulate, one tap per cycle, followed by one rounding cycle and
// one output cycle. Define FIR_DECIM2_SAT_EN to saturate the narrowed output;
// leave it undefined for two's-complement wrap.
module fir_decim2 #(
  parameter int unsigned IN_WIDTH   = 18,
  parameter int unsigned OUT_WIDTH  = 18,
  parameter int unsigned COEF_WIDTH = 18,
  parameter int unsigned TAPS       = 32,
  parameter int unsigned ACC_WIDTH  = 48
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic                         in_strobe,
  input  logic signed [IN_WIDTH-1:0]   in_data,
  input  logic                         coef_we,
  input  logic [$clog2(TAPS)-1:0]      coef_addr,
  input  logic signed [COEF_WIDTH-1:0] coef_data,
  output logic                         out_strobe,
  output logic signed [OUT_WIDTH-1:0]  out_data,
  output logic                         busy,
  output logic                         overrun
);

  localparam int unsigned AddrW = $clog2(TAPS);
  localparam int unsigned PtrW  = AddrW + 1;
  localparam int unsigned Depth = 2 * TAPS;
  localparam int unsigned ProdW = IN_WIDTH + COEF_WIDTH;
  localparam int unsigned RndW  = ACC_WIDTH - COEF_WIDTH + 1;

  localparam logic [ACC_WIDTH-1:0] RndBias = ACC_WIDTH'(1) << (COEF_WIDTH - 2);
  localparam logic [AddrW-1:0]     LastTap = AddrW'(TAPS - 1);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StMac   = 2'd1;
  localparam logic [1:0] StRound = 2'd2;
  localparam logic [1:0] StOut   = 2'd3;

  logic [1:0]                   state_q, state_d;
  logic [PtrW-1:0]              wr_ptr_q;
  logic                         phase_q;
  logic [PtrW-1:0]              n_q, n_d;
  logic [AddrW-1:0]             k_q, k_d;
  logic signed [ACC_WIDTH-1:0]  acc_q, acc_d;
  logic                         out_strobe_q, out_strobe_d;
  logic signed [OUT_WIDTH-1:0]  out_data_q, out_data_d;
  logic                         overrun_q;

  logic signed [IN_WIDTH-1:0]   ring_q [Depth];
  logic signed [COEF_WIDTH-1:0] coef_q [TAPS];

  logic                         busy_w;
  logic                         trigger;
  logic [PtrW-1:0]              rd_idx;
  logic signed [IN_WIDTH-1:0]   tap_sample;
  logic signed [COEF_WIDTH-1:0] tap_coef;
  logic signed [ProdW-1:0]      prod;
  logic signed [ACC_WIDTH-1:0]  prod_ext;
  logic [ACC_WIDTH-1:0]         acc_rnd;
  logic [RndW-1:0]              r_w;
  logic [OUT_WIDTH-1:0]         narrowed;
  logic                         unused_bits;

  assign busy_w  = (state_q != StIdle);
  assign trigger = in_strobe & phase_q;

  // Tap k reads the sample k positions older than the trigger sample.
  assign rd_idx     = n_q - {1'b0, k_q};
  assign tap_sample = ring_q[rd_idx];
  assign tap_coef   = coef_q[k_q];
  assign prod       = ProdW'(tap_sample) * ProdW'(tap_coef);
  assign prod_ext   = ACC_WIDTH'(prod);

  // Round half up, then drop the Q1.(COEF_WIDTH-1) fraction bits.
  assign acc_rnd = acc_q + RndBias;
  assign r_w     = acc_rnd[ACC_WIDTH-1:COEF_WIDTH-1];

`ifdef FIR_DECIM2_SAT_EN
  logic fits;
  assign fits     = (&r_w[RndW-1:OUT_WIDTH-1]) | ~(|r_w[RndW-1:OUT_WIDTH-1]);
  assign narrowed = fits      ? r_w[OUT_WIDTH-1:0] :
                    r_w[RndW-1] ? {1'b1, {(OUT_WIDTH-1){1'b0}}} :
                                  {1'b0, {(OUT_WIDTH-1){1'b1}}};
  assign unused_bits = ^acc_rnd[COEF_WIDTH-2:0];
`else
  assign narrowed    = r_w[OUT_WIDTH-1:0];
  assign unused_bits = ^{acc_rnd[COEF_WIDTH-2:0], r_w[RndW-1:OUT_WIDTH]};
`endif

  // Next-state for the MAC sequencer and the output registers.
  always_comb begin
    state_d      = state_q;
    n_d          = n_q;
    k_d          = k_q;
    acc_d        = acc_q;
    out_strobe_d = 1'b0;
    out_data_d   = out_data_q;
    unique case (state_q)
      StIdle: begin
        if (trigger) begin
          state_d = StMac;
          n_d     = wr_ptr_q;
          k_d     = '0;
          acc_d   = '0;
        end
      end
      StMac: begin
        acc_d = acc_q + prod_ext;
        k_d   = k_q + 1'b1;
        if (k_q == LastTap) state_d = StRound;
      end
      StRound: begin
        // Loaded here so the value is on out_data for the whole OUT cycle.
        out_data_d   = narrowed;
        out_strobe_d = 1'b1;
        state_d      = StOut;
      end
      StOut: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Control state, accumulator and output registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      wr_ptr_q     <= '0;
      phase_q      <= 1'b0;
      n_q          <= '0;
      k_q          <= '0;
      acc_q        <= '0;
      out_strobe_q <= 1'b0;
      out_data_q   <= '0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      n_q          <= n_d;
      k_q          <= k_d;
      acc_q        <= acc_d;
      out_strobe_q <= out_strobe_d;
      out_data_q   <= out_data_d;
      overrun_q    <= trigger & busy_w;
      if (in_strobe) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
        phase_q  <= ~phase_q;
      end
    end
  end

  // Sample ring; written on every strobe, even while a MAC is running.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(Depth); i++) ring_q[i] <= '0;
    end else if (in_strobe) begin
      ring_q[wr_ptr_q] <= in_data;
    end
  end

  // Coefficient store: no reset, writable only while idle.
  always_ff @(posedge clock) begin
    if (coef_we && !busy_w) coef_q[coef_addr] <= coef_data;
  end

  assign out_strobe = out_strobe_q;
  assign out_data   = out_data_q;
  assign busy       = busy_w;
  assign overrun    = overrun_q;

endmodule
